branch_target_reader: RTL
=========================

# branch_target_reader

Read-side companion to the branch-destination-address register in the fetch path. The block runs the fetch program counter and accepts fetch handshakes. When a taken branch is signalled, it selects the branch-destination register onto the shared tri-state address bus, samples the bus, and redirects the PC to the captured address. All state advances only on clock edges where `Tick` is high, which matches the clock-enable scheme of the register file it reads.

## Interface
- `ADDR_BITS`, default 8: width of the PC and of the address bus.
- `RESET_PC`, default 0: PC value loaded on reset.
- `SETTLE_TICKS`, default 1, legal range 1–15: number of Ticks the bus stays selected before it is sampled.
- `Clock` in 1: system clock. All flops are rising-edge.
- `Reset` in 1: asynchronous, active-high.
- `Tick` in 1: global clock-enable. A flop updates only on a Clock edge where Tick=1.
- `branch_req` in 1: branch resolution strobe, sampled on Tick edges.
- `branch_taken` in 1: qualifies `branch_req`. 1 = taken.
- `bus_d` in ADDR_BITS: shared address bus, driven by the selected register.
- `bus_cs` out 1: select to the branch-destination register. 1 = register released (its output is Z); 0 = register drives `bus_d`.
- `fetch_ready` in 1: fetch stage accepts `pc`.
- `pc` out ADDR_BITS: current fetch address.
- `pc_valid` out 1: `pc` is valid for fetch.
- `busy` out 1: a redirect is in progress (state is not RUN).
- `redirect_done` out 1: one-Clock pulse on the edge that loads the captured address into `pc`.
- `branch_overrun` out 1: sticky flag, set when a taken branch arrives while busy. Cleared only by Reset.

## Operation
- States:
  - RUN: `pc_valid`=1, `bus_cs`=1.
  - SELECT: `bus_cs`=0, `pc_valid`=0; settle counter active.
  - REDIRECT: `bus_cs`=1, `pc_valid`=0.
- RUN, on a Tick edge:
  - `branch_req`&`branch_taken` → go to SELECT, load settle counter with `SETTLE_TICKS`-1.
  - Otherwise, if `pc_valid`&`fetch_ready` → `pc` <= `pc`+1, modulo 2^ADDR_BITS (all-ones wraps to 0).
- `branch_req` with `branch_taken`=0 is a no-op. Normal increment rules apply.
- Simultaneous fetch handshake and taken branch: the handshake consumes the current `pc`, the branch wins, and `pc` is not incremented.
- SELECT, on a Tick edge:
  - Counter ≠ 0 → decrement.
  - Counter = 0 → capture `bus_d` into the target register, go to REDIRECT.
- REDIRECT, on a Tick edge: `pc` <= captured target, `redirect_done`=1 for that Clock cycle, go to RUN.
- Taken `branch_req` in SELECT or REDIRECT: ignored, and `branch_overrun` <= 1.
- When Tick=0, state, `pc`, counter and flags all hold. `redirect_done` drops after one Clock cycle regardless of Tick.
- Arithmetic is unsigned ADDR_BITS only, with no carry out.

## Timing
- Reset values: state=RUN, `pc`=`RESET_PC`, `pc_valid`=1, `bus_cs`=1, `busy`=0, `redirect_done`=0, `branch_overrun`=0, target register=0.
- All outputs are registered or decoded from the state register. There is no combinational path from inputs to outputs.
- Redirect latency with Tick continuously high, taken branch sampled at edge k:
  - `bus_cs`=0 from edge k to edge k+`SETTLE_TICKS`.
  - `bus_d` is sampled at edge k+`SETTLE_TICKS`.
  - `pc` = target and `pc_valid`=1 after edge k+`SETTLE_TICKS`+1.
  - Total: `SETTLE_TICKS`+1 Ticks.
- `bus_cs` is high for the entire REDIRECT state, so the bus is never driven when `pc` changes.
- Reset asserted mid-redirect: `bus_cs` goes to 1 immediately (asynchronously). The captured target is discarded and `pc`=`RESET_PC`.
- Reset release is synchronous to the next Clock edge. The first Tick edge after release may accept a fetch handshake.

## Test plan
- Reset, then 4 Ticks with `fetch_ready`=1 → `pc` goes 0,1,2,3,4; `bus_cs`=1 and `busy`=0 throughout.
- ADDR_BITS=8 with `pc`=8'hFF, handshake → `pc`=8'h00 with no other side effects.
- SETTLE_TICKS=1, `bus_d`=8'h5A, taken branch at edge k → `bus_cs`=0 from edge k to edge k+1; `redirect_done` pulses at edge k+2; `pc`=8'h5A and `pc_valid`=1 after edge k+2.
- SETTLE_TICKS=3, Tick high on alternate cycles → `bus_cs`=0 for exactly 3 Tick edges and is held across the non-Tick cycles; `pc` loads the bus value.
- Second taken branch while in SELECT → ignored; `branch_overrun`=1 until Reset; the first target still loads.
- Reset pulsed while in SELECT → `bus_cs`=1 within the same cycle; `pc`=`RESET_PC`; `redirect_done` never pulses.

Source files
------------

// File: rtl/branch_target_reader_if.sv
// rtl/branch_target_reader_if.sv - fetch, branch and address-bus signals of branch_target_reader

interface branch_target_reader_if #(
  parameter int ADDR_BITS = 8
);

  // branch resolution
  logic                 branch_req;
  logic                 branch_taken;

  // shared address bus and select to the branch-destination register
  logic [ADDR_BITS-1:0] bus_d;
  logic                 bus_cs;

  // fetch handshake
  logic                 fetch_ready;
  logic [ADDR_BITS-1:0] pc;
  logic                 pc_valid;

  // status
  logic                 busy;
  logic                 redirect_done;
  logic                 branch_overrun;

  // master drives the branch strobe, the bus and the fetch-side ready
  modport master (
    output branch_req,
    output branch_taken,
    output bus_d,
    output fetch_ready,
    input  bus_cs,
    input  pc,
    input  pc_valid,
    input  busy,
    input  redirect_done,
    input  branch_overrun
  );

  // slave is the reader itself
  modport slave (
    input  branch_req,
    input  branch_taken,
    input  bus_d,
    input  fetch_ready,
    output bus_cs,
    output pc,
    output pc_valid,
    output busy,
    output redirect_done,
    output branch_overrun
  );

endinterface

// File: rtl/branch_target_reader.sv
// rtl/branch_target_reader.sv - fetch PC with branch redirect read from the branch-destination register

module branch_target_reader #(
  parameter int                   ADDR_BITS    = 8,
  parameter logic [ADDR_BITS-1:0] RESET_PC     = '0,
  parameter int                   SETTLE_TICKS = 1
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Tick,
  branch_target_reader_if.slave  brt
);

  // settle counter counts down to zero, so it starts one below the tick count
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_TICKS - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SELECT   = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] pc_q, pc_d;
  logic [ADDR_BITS-1:0] target_q, target_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 overrun_q, overrun_d;
  logic                 done_q, done_d;
  logic                 take;

  assign take = brt.branch_req & brt.branch_taken;

  // next-state: every update is gated by Tick except the one-cycle done pulse
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    target_d  = target_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;
    done_d    = 1'b0;

    if (Tick) begin
      case (state_q)
        ST_RUN: begin
          // a taken branch wins over the handshake; the handshake still consumes pc
          if (take) begin
            state_d = ST_SELECT;
            cnt_d   = SETTLE_LOAD;
          end else if (brt.fetch_ready) begin
            pc_d = pc_q + ADDR_BITS'(1);
          end
        end

        ST_SELECT: begin
          if (take) begin
            overrun_d = 1'b1;
          end
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            target_d = brt.bus_d;
            state_d  = ST_REDIRECT;
          end
        end

        ST_REDIRECT: begin
          if (take) begin
            overrun_d = 1'b1;
          end
          pc_d    = target_q;
          done_d  = 1'b1;
          state_d = ST_RUN;
        end

        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // state register; Reset releases the bus at once because bus_cs decodes from state
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_PC;
      target_q  <= '0;
      cnt_q     <= 4'd0;
      overrun_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      target_q  <= target_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
      done_q    <= done_d;
    end
  end

  // outputs come only from flops or from the state decode
  assign brt.bus_cs         = (state_q != ST_SELECT);
  assign brt.pc_valid       = (state_q == ST_RUN);
  assign brt.busy           = (state_q != ST_RUN);
  assign brt.pc             = pc_q;
  assign brt.redirect_done  = done_q;
  assign brt.branch_overrun = overrun_q;

  // the register may only drive the bus while fetch is stalled
  always @(posedge Clock) begin
    assert (brt.bus_cs || !brt.pc_valid);
    assert (!brt.redirect_done || brt.pc_valid);
  end

endmodule
